pb_debouncer: RTL and testbench
===============================

Name: pb_debouncer

Overview:
- Front-end conditioning stage for the 5 board push buttons.
- Synchronises the raw active-low PB pins and debounces each button independently.
- Emits clean, active-high levels plus single-cycle press, release and auto-repeat strobes.
- Feeds the downstream button-driven counter and display logic, which then counts strobes and needs no delay loops of its own.

Parameters:
- NUM_PB, 5, number of button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a level change (>=1).
- REPEAT_DELAY, 25000000, cycles from press_pulse to first repeat_pulse while held (>=1).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat_pulse strobes while held (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- PB  input  NUM_PB  raw asynchronous button pins, 0 = pressed.
- repeat_en  input  NUM_PB  per-button auto-repeat enable, sampled every cycle.
- pb_level  output  NUM_PB  debounced state, 1 = pressed.
- press_pulse  output  NUM_PB  1-cycle strobe when pb_level goes 0->1.
- release_pulse  output  NUM_PB  1-cycle strobe when pb_level goes 1->0.
- repeat_pulse  output  NUM_PB  1-cycle auto-repeat strobe while held.

Behaviour:
- Reset, with rst_n=0 at a clk edge:
  - Both synchroniser stages load 1 (released).
  - All debounce and repeat counters clear.
  - pb_level, press_pulse, release_pulse and repeat_pulse all go to 0.
  - Reset mid-press returns the channel to released silently: no release_pulse is generated.
- Synchroniser: 2 flops per bit, s1<=PB, s2<=s1. The debouncer compares ~s2 with pb_level.
- Debounce counter (per channel, width $clog2(DEBOUNCE_CYCLES+1)):
  - When ~s2 != pb_level, the counter increments.
  - When ~s2 == pb_level, the counter clears to 0. Any glitch shorter than DEBOUNCE_CYCLES therefore restarts the count.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample: pb_level toggles, the counter clears, and the matching press_pulse or release_pulse is asserted for exactly that one cycle.
  - Latency: if raw PB is first sampled low at edge k and stays low, pb_level and press_pulse are high after edge k+1+DEBOUNCE_CYCLES. Release is symmetric.
- Repeat FSM (per channel), states IDLE, WAIT_FIRST, REPEATING:
  - IDLE: entered from reset or any release. The repeat counter is held at 0. On press_pulse, go to WAIT_FIRST with the counter at 0.
  - WAIT_FIRST: the counter increments each cycle.
    - If repeat_en=1 when the counter reaches REPEAT_DELAY-1: assert repeat_pulse for 1 cycle, clear the counter, go to REPEATING.
    - If repeat_en=0 at that point: stay in WAIT_FIRST with the counter saturated, and no pulse.
    - If repeat_en later rises while saturated: repeat_pulse fires on the next cycle.
  - REPEATING: the counter increments. When it reaches REPEAT_PERIOD-1 and repeat_en=1: assert repeat_pulse, clear the counter. If repeat_en=0: the counter saturates and no pulse fires.
  - Release (pb_level falling) from any state: go to IDLE and clear the counter. repeat_pulse is never asserted in the same cycle as release_pulse.
  - repeat_pulse is never asserted in the same cycle as press_pulse.
- Channels are fully independent. Any combination of strobes on different bits may coincide.
- All outputs are registered. No combinational path exists from PB or repeat_en to any output.
- Counter arithmetic is unsigned with no wrap. Every counter clears or saturates before overflow.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated.

- Reset: hold rst_n=0 for 3 cycles with PB=5'b00000 → all outputs 0. After release of rst_n with PB held low, pb_level=5'b11111 and press_pulse=5'b11111 after edge 1+4 counted from the first post-reset sample.
- Clean press on PB[3]: PB[3] 1->0 sampled at edge k → press_pulse[3]=1 only after edge k+5, pb_level[3]=1 thereafter. Release gives release_pulse[3] 5 edges after the first high sample.
- Bounce on PB[0]: pattern low 3 cycles, high 1, low 3, high 1 → no strobe and pb_level[0] stays 0. A subsequent 4 stable low cycles gives exactly one press_pulse[0].
- Auto-repeat on PB[1], repeat_en[1]=1, held 30 cycles after press_pulse → repeat_pulse[1] at press+10, +13, +16, +19, +22, ..., until release. Release gives release_pulse[1] and no further repeats.
- Repeat gating: same hold with repeat_en[1]=0 → zero repeat pulses. Raising repeat_en[1] at press+15 gives a repeat_pulse 1 cycle later, then every 3 cycles.
- Reset mid-hold on PB[2] (pb_level[2]=1): assert rst_n=0 for 1 cycle → pb_level[2]=0, no release_pulse. With PB[2] still low, a fresh press_pulse[2] fires 4 samples after synchroniser refill.

Source files
------------

// File: rtl/pb_debouncer.sv
// Push-button front end: 2-flop synchroniser, per-channel debounce counter and
// auto-repeat FSM producing clean levels plus press/release/repeat strobes.
module pb_debouncer #(
  parameter int unsigned NUM_PB          = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] PB,
  input  logic [NUM_PB-1:0] repeat_en,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] press_pulse,
  output logic [NUM_PB-1:0] release_pulse,
  output logic [NUM_PB-1:0] repeat_pulse
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  localparam logic [DbW-1:0]  DbLast       = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RptW-1:0] RptDelayLast = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPerLast   = RptW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWaitFirst,
    StRepeating
  } rpt_state_e;

  // Synchroniser resets to 1 so a held button looks released until refilled.
  logic [NUM_PB-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= PB;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_PB; i++) begin : g_chan
    logic [DbW-1:0]  db_cnt_q;
    logic [RptW-1:0] rpt_cnt_q;
    rpt_state_e      state_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            repeat_q;
    logic            pressed;
    logic            db_done;

    assign pressed = ~sync2_q[i];
    assign db_done = (pressed != level_q) && (db_cnt_q == DbLast);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        state_q   <= StIdle;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;

        if (pressed == level_q) begin
          db_cnt_q <= '0;
        end else if (db_done) begin
          db_cnt_q  <= '0;
          level_q   <= pressed;
          press_q   <= pressed;
          release_q <= ~pressed;
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end

        // An accepted release overrides any repeat that would be due this cycle.
        if (db_done && !pressed) begin
          state_q   <= StIdle;
          rpt_cnt_q <= '0;
        end else begin
          case (state_q)
            StIdle: begin
              rpt_cnt_q <= '0;
              if (db_done && pressed) begin
                state_q <= StWaitFirst;
              end
            end
            StWaitFirst: begin
              if (rpt_cnt_q == RptDelayLast) begin
                if (repeat_en[i]) begin
                  repeat_q  <= 1'b1;
                  rpt_cnt_q <= '0;
                  state_q   <= StRepeating;
                end
              end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
              end
            end
            StRepeating: begin
              if (rpt_cnt_q == RptPerLast) begin
                if (repeat_en[i]) begin
                  repeat_q  <= 1'b1;
                  rpt_cnt_q <= '0;
                end
              end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
              end
            end
            default: begin
              state_q   <= StIdle;
              rpt_cnt_q <= '0;
            end
          endcase
        end
      end
    end

    assign pb_level[i]      = level_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule

// File: tb/tb_pb_debouncer.sv
// Directed, table-driven bench for pb_debouncer with short debounce/repeat timings.
module tb_pb_debouncer;

  localparam int unsigned NumPb = 5;

  logic             clk;
  logic             rst_n;
  logic [NumPb-1:0] pb;
  logic [NumPb-1:0] repeat_en;
  logic [NumPb-1:0] pb_level;
  logic [NumPb-1:0] press_pulse;
  logic [NumPb-1:0] release_pulse;
  logic [NumPb-1:0] repeat_pulse;

  pb_debouncer #(
    .NUM_PB         (NumPb),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PB           (pb),
    .repeat_en    (repeat_en),
    .pb_level     (pb_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned      n;
    logic             rst_n;
    logic [NumPb-1:0] pb;
    logic [NumPb-1:0] ren;
    logic [NumPb-1:0] lvl;
    logic [NumPb-1:0] prs;
    logic [NumPb-1:0] rel;
    logic [NumPb-1:0] rpt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_no  = 0;

  function automatic void row(int unsigned n, logic r, logic [4:0] p, logic [4:0] e,
                              logic [4:0] l, logic [4:0] pr, logic [4:0] rl, logic [4:0] rp);
    vec_t v;
    v.n = n; v.rst_n = r; v.pb = p; v.ren = e;
    v.lvl = l; v.prs = pr; v.rel = rl; v.rpt = rp;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [NumPb-1:0] act, logic [NumPb-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_no, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    bit seen;

    rst_n     = 1'b0;
    pb        = '1;
    repeat_en = '0;

    // Reset with all buttons down, then press on all channels.
    row(3, 0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h00, 5'h00, 5'h1F, 5'h1F, 5'h00, 5'h00);
    row(12, 1, 5'h00, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h1F, 5'h00, 5'h1F, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h1F, 5'h00);
    row(3, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    // Clean press/release on PB[3].
    row(5, 1, 5'h17, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h17, 5'h00, 5'h08, 5'h08, 5'h00, 5'h00);
    row(3, 1, 5'h17, 5'h00, 5'h08, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h1F, 5'h00, 5'h08, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h08, 5'h00);
    row(2, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    // Bounce on PB[0], then a stable press.
    row(3, 1, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(3, 1, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h1E, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1E, 5'h00, 5'h01, 5'h01, 5'h00, 5'h00);
    row(3, 1, 5'h1E, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h1F, 5'h00, 5'h01, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h01, 5'h00);
    row(2, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    // Auto-repeat on PB[1]; release lands on a cycle where a repeat was due.
    row(5, 1, 5'h1D, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h02, 5'h00, 5'h00);
    row(9, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    for (int i = 0; i < 6; i++) begin
      row(2, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
      row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    end
    row(2, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    row(2, 1, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    row(2, 1, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h02, 5'h00, 5'h00, 5'h02, 5'h00);
    row(6, 1, 5'h1F, 5'h02, 5'h00, 5'h00, 5'h00, 5'h00);
    // Repeat gating: enable low past the delay, then raised at press+16.
    row(5, 1, 5'h1D, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h00, 5'h02, 5'h02, 5'h00, 5'h00);
    row(15, 1, 5'h1D, 5'h00, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    row(2, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    row(2, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1D, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    row(2, 1, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00, 5'h02);
    row(2, 1, 5'h1F, 5'h02, 5'h02, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h02, 5'h00, 5'h00, 5'h02, 5'h00);
    row(4, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    // Reset while PB[2] is held: silent drop, then fresh press after refill.
    row(5, 1, 5'h1B, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1B, 5'h00, 5'h04, 5'h04, 5'h00, 5'h00);
    row(3, 1, 5'h1B, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00);
    row(1, 0, 5'h1B, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h1B, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1B, 5'h00, 5'h04, 5'h04, 5'h00, 5'h00);
    row(2, 1, 5'h1B, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00);
    row(5, 1, 5'h1F, 5'h00, 5'h04, 5'h00, 5'h00, 5'h00);
    row(1, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h04, 5'h00);
    row(2, 1, 5'h1F, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

    foreach (vecs[r]) begin
      for (int j = 0; j < int'(vecs[r].n); j++) begin
        rst_n     = vecs[r].rst_n;
        pb        = vecs[r].pb;
        repeat_en = vecs[r].ren;
        tick();
        check("pb_level", pb_level, vecs[r].lvl);
        check("press_pulse", press_pulse, vecs[r].prs);
        check("release_pulse", release_pulse, vecs[r].rel);
        check("repeat_pulse", repeat_pulse, vecs[r].rpt);
      end
    end

    // Hand sequence on PB[4]: measure repeat spacing with bounded waits.
    pb        = 5'h0F;
    repeat_en = 5'h10;
    seen      = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = press_pulse[4];
    end
    check_int("pb4_press_seen", int'(seen), 1);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      cnt++;
      seen = repeat_pulse[4];
    end
    check_int("pb4_first_repeat_delay", cnt, 10);
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      tick();
      cnt++;
      seen = repeat_pulse[4];
    end
    check_int("pb4_repeat_period", cnt, 3);
    pb   = 5'h1F;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = release_pulse[4];
    end
    check_int("pb4_release_seen", int'(seen), 1);
    check("pb4_level_after_release", pb_level, 5'h00);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (repeat_pulse[4]) cnt++;
    end
    check_int("pb4_no_repeat_after_release", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
